// File: rtl/risc16_prog_loader_pkg.sv
// Shared definitions for the RiSC16 program loader: FSM state encoding and
// the default post-programming reset stretch.
package risc16_prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WRITE  = 3'd2,
        S_FLUSH  = 3'd3,
        S_RUN    = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam int RST_CYCLES_DEF = 2;

    // Width of a counter that must hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/risc16_prog_loader_if.sv
// Word-stream input and instruction-memory write bus between a host, the
// program loader and the RiSC16 system.
interface risc16_prog_loader_if #(parameter int WORD_LENGTH = 16);

    logic                   in_valid;
    logic [WORD_LENGTH-1:0] in_data;
    logic                   in_last;
    logic                   in_ready;
    logic                   pen;
    logic [WORD_LENGTH-1:0] addr;
    logic [WORD_LENGTH-1:0] instr;
    logic                   sys_rst;
    logic                   done;
    logic                   err;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, pen, addr, instr, sys_rst, done, err
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, pen, addr, instr, sys_rst, done, err
    );

endinterface

// File: rtl/risc16_loader_cksum.sv
// Modular sum of the program words written by the loader, compared against
// the trailing checksum word. Only built with LOADER_CHECKSUM_EN.
module risc16_loader_cksum #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   add,
    input  logic [WORD_LENGTH-1:0] word,
    output logic                   match
);

    logic [WORD_LENGTH-1:0] sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sum <= '0;
        else if (clr)
            sum <= '0;
        else if (add)
            sum <= sum + word;
    end

    // Same input word serves as addend in data phase and reference in check phase.
    assign match = (sum == word);

endmodule

// File: rtl/risc16_prog_loader.sv
// Streams program words into RiSC16 instruction memory, then releases the
// system from reset. Optional trailing checksum: define LOADER_CHECKSUM_EN.
module risc16_prog_loader
    import risc16_prog_loader_pkg::*;
#(
    parameter int                     WORD_LENGTH = 16,
    parameter logic [WORD_LENGTH-1:0] BASE_ADDR   = '0,
    parameter int                     RST_CYCLES  = RST_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    risc16_prog_loader_if.slave lif
);

    // RST_CYCLES below 1 behaves as 1: FLUSH always lasts at least one cycle.
    localparam int           CW       = cnt_width(RST_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = (RST_CYCLES > 1) ? CW'(RST_CYCLES - 1) : '0;

    state_t                 state, state_n;
    logic [WORD_LENGTH-1:0] addr_q, addr_n;
    logic [WORD_LENGTH-1:0] instr_q, instr_n;
    logic                   last_q, last_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   pen_q, pen_n;
    logic                   rdy_q, srst_q, done_q, err_q;

`ifdef LOADER_CHECKSUM_EN
    logic ckph, ckph_n;
    logic ck_clr, ck_add, ck_match;

    risc16_loader_cksum #(.WORD_LENGTH(WORD_LENGTH)) u_cksum (
        .clk   (clk),
        .rst   (rst),
        .clr   (ck_clr),
        .add   (ck_add),
        .word  (lif.in_data),
        .match (ck_match)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            addr_q  <= BASE_ADDR;
            instr_q <= '0;
            last_q  <= 1'b0;
            cnt     <= '0;
            pen_q   <= 1'b0;
            rdy_q   <= 1'b0;
            srst_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            ckph    <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            addr_q  <= addr_n;
            instr_q <= instr_n;
            last_q  <= last_n;
            cnt     <= cnt_n;
            // Outputs are decoded from the next state so they leave the flops aligned with it.
            pen_q   <= pen_n;
            rdy_q   <= (state_n == S_ACCEPT);
            srst_q  <= (state_n != S_RUN);
            done_q  <= (state_n == S_RUN);
            err_q   <= (state_n == S_ERROR);
`ifdef LOADER_CHECKSUM_EN
            ckph    <= ckph_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        instr_n = instr_q;
        last_n  = last_q;
        cnt_n   = cnt;
`ifdef LOADER_CHECKSUM_EN
        ckph_n  = ckph;
        ck_clr  = 1'b0;
        ck_add  = 1'b0;
`endif
        case (state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    state_n = S_ACCEPT;
                    addr_n  = BASE_ADDR;
                    cnt_n   = '0;
`ifdef LOADER_CHECKSUM_EN
                    ckph_n  = 1'b0;
                    ck_clr  = 1'b1;
`endif
                end
            end
            S_ACCEPT: begin
                if (lif.in_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    if (ckph) begin
                        ckph_n  = 1'b0;
                        cnt_n   = '0;
                        state_n = ck_match ? S_FLUSH : S_ERROR;
                    end else begin
                        instr_n = lif.in_data;
                        last_n  = lif.in_last;
                        ck_add  = 1'b1;
                        state_n = S_WRITE;
                    end
`else
                    instr_n = lif.in_data;
                    last_n  = lif.in_last;
                    state_n = S_WRITE;
`endif
                end
            end
            S_WRITE: begin
                if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
                    ckph_n  = 1'b1;
                    state_n = S_ACCEPT;
`else
                    cnt_n   = '0;
                    state_n = S_FLUSH;
`endif
                end else if (&addr_q) begin
                    // More words would wrap past the top of memory.
                    state_n = S_ERROR;
                end else begin
                    addr_n  = addr_q + WORD_LENGTH'(1);
                    state_n = S_ACCEPT;
                end
            end
            S_FLUSH: begin
                if (cnt == CNT_LAST)
                    state_n = S_RUN;
                else
                    cnt_n = cnt + CW'(1);
            end
            default: state_n = S_IDLE;
        endcase

        pen_n = (state_n == S_WRITE) || (state_n == S_ACCEPT);
`ifdef LOADER_CHECKSUM_EN
        if (ckph_n)
            pen_n = 1'b0;
`endif
    end

    assign lif.in_ready = rdy_q;
    assign lif.pen      = pen_q;
    assign lif.addr     = addr_q;
    assign lif.instr    = instr_q;
    assign lif.sys_rst  = srst_q;
    assign lif.done     = done_q;
    assign lif.err      = err_q;

endmodule

// File: tb/tb_risc16_prog_loader.sv
// Directed bench for risc16_prog_loader; status vector is {pen,in_ready,sys_rst,done,err}.
module tb_risc16_prog_loader;

    logic clk, rst, start, start2;
    int   tests, fails;

    risc16_prog_loader_if #(.WORD_LENGTH(16)) lif  ();
    risc16_prog_loader_if #(.WORD_LENGTH(16)) lif2 ();

    risc16_prog_loader dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .lif   (lif.slave)
    );

    risc16_prog_loader #(.BASE_ADDR(16'hFFFF)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .lif   (lif2.slave)
    );

    localparam logic [4:0] ST_IDLE = 5'b00100, ST_ACC = 5'b11100, ST_WR  = 5'b10100;
    localparam logic [4:0] ST_FL   = 5'b00100, ST_RUN = 5'b00010, ST_ERR = 5'b00101;

    wire [4:0] st  = {lif.pen,  lif.in_ready,  lif.sys_rst,  lif.done,  lif.err};
    wire [4:0] st2 = {lif2.pen, lif2.in_ready, lif2.sys_rst, lif2.done, lif2.err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic l);
        lif.in_valid = 1'b1; lif.in_data = d; lif.in_last = l;
        tick();
        lif.in_valid = 1'b0; lif.in_last = 1'b0;
    endtask

    task automatic push2(input logic [15:0] d, input logic l);
        lif2.in_valid = 1'b1; lif2.in_data = d; lif2.in_last = l;
        tick();
        lif2.in_valid = 1'b0; lif2.in_last = 1'b0;
    endtask

    // From the last WRITE cycle to the first FLUSH cycle (via the checksum word if built in).
    task automatic to_flush(input logic [15:0] sum);
`ifdef LOADER_CHECKSUM_EN
        tick();
        push(sum, 1'b0);
`else
        tick();
        if (sum === 16'hxxxx) $display("unused");
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        tests++;
        if (st !== ST_IDLE) begin fails++; $display("FAIL reset_status got %b want %b", st, ST_IDLE); end
        tests++;
        if ({lif.addr, lif.instr} !== 32'h0000_0000) begin
            fails++; $display("FAIL reset_addr_instr got %h/%h want 0000/0000", lif.addr, lif.instr);
        end
        tests++;
        if (lif2.addr !== 16'hFFFF) begin fails++; $display("FAIL reset_base2 got %h want FFFF", lif2.addr); end
        @(negedge clk) rst = 1'b1;
        tick();
        tests++;
        if (st !== ST_IDLE) begin fails++; $display("FAIL idle_hold got %b want %b", st, ST_IDLE); end
    endtask

    task automatic test_load();
        pulse_start();
        tests++;
        if (st !== ST_ACC || lif.addr !== 16'h0000) begin
            fails++; $display("FAIL load_accept got %b/%h want %b/0000", st, lif.addr, ST_ACC);
        end
        push(16'h6A00, 1'b0);
        tests++;
        if (st !== ST_WR || lif.addr !== 16'h0000 || lif.instr !== 16'h6A00) begin
            fails++; $display("FAIL load_w0 got %b %h %h want %b 0000 6A00", st, lif.addr, lif.instr, ST_WR);
        end
        tick();
        tests++;
        if (st !== ST_ACC || lif.addr !== 16'h0001) begin
            fails++; $display("FAIL load_inc got %b/%h want %b/0001", st, lif.addr, ST_ACC);
        end
        push(16'h6D00, 1'b0);
        tests++;
        if (st !== ST_WR || lif.addr !== 16'h0001 || lif.instr !== 16'h6D00) begin
            fails++; $display("FAIL load_w1 got %b %h %h want %b 0001 6D00", st, lif.addr, lif.instr, ST_WR);
        end
        tick();
        push(16'h0903, 1'b1);
        tests++;
        if (st !== ST_WR || lif.addr !== 16'h0002 || lif.instr !== 16'h0903) begin
            fails++; $display("FAIL load_w2 got %b %h %h want %b 0002 0903", st, lif.addr, lif.instr, ST_WR);
        end
        to_flush(16'hE003);
        tests++;
        if (st !== ST_FL) begin fails++; $display("FAIL load_flush1 got %b want %b", st, ST_FL); end
        tick();
        tests++;
        if (st !== ST_FL) begin fails++; $display("FAIL load_flush2 got %b want %b", st, ST_FL); end
        tick();
        tests++;
        if (st !== ST_RUN) begin fails++; $display("FAIL load_run got %b want %b", st, ST_RUN); end
    endtask

    task automatic test_reload();
        pulse_start();
        tests++;
        if (st !== ST_ACC || lif.addr !== 16'h0000) begin
            fails++; $display("FAIL reload_accept got %b/%h want %b/0000", st, lif.addr, ST_ACC);
        end
        push(16'hABCD, 1'b1);
        tests++;
        if (st !== ST_WR || lif.addr !== 16'h0000 || lif.instr !== 16'hABCD) begin
            fails++; $display("FAIL reload_w got %b %h %h want %b 0000 ABCD", st, lif.addr, lif.instr, ST_WR);
        end
        to_flush(16'hABCD);
        tick();
        tick();
        tests++;
        if (st !== ST_RUN) begin fails++; $display("FAIL reload_run got %b want %b", st, ST_RUN); end
    endtask

    task automatic test_stall();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (st !== ST_ACC || lif.addr !== 16'h0000) begin
                fails++; $display("FAIL stall_%0d got %b/%h want %b/0000", i, st, lif.addr, ST_ACC);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        push(16'h1111, 1'b0);
        tick();
        push(16'h2222, 1'b0);
        tests++;
        if (st !== ST_WR || lif.addr !== 16'h0001) begin
            fails++; $display("FAIL midrst_w1 got %b/%h want %b/0001", st, lif.addr, ST_WR);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (st !== ST_IDLE || lif.addr !== 16'h0000 || lif.instr !== 16'h0000) begin
            fails++; $display("FAIL midrst_async got %b %h %h want %b 0000 0000", st, lif.addr, lif.instr, ST_IDLE);
        end
        @(negedge clk) rst = 1'b1;
        lif.in_valid = 1'b1; lif.in_data = 16'h3333;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (st !== ST_IDLE) begin fails++; $display("FAIL midrst_nopen_%0d got %b want %b", i, st, ST_IDLE); end
        end
        lif.in_valid = 1'b0;
    endtask

    task automatic test_start_ignored();
        pulse_start();
        push(16'h5555, 1'b1);
        to_flush(16'h5555);
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (st !== ST_FL) begin fails++; $display("FAIL ign_flush got %b want %b", st, ST_FL); end
        tick();
        tests++;
        if (st !== ST_RUN) begin fails++; $display("FAIL ign_run got %b want %b", st, ST_RUN); end
    endtask

    task automatic test_wrap();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tests++;
        if (st2 !== ST_ACC || lif2.addr !== 16'hFFFF) begin
            fails++; $display("FAIL wrap_accept got %b/%h want %b/FFFF", st2, lif2.addr, ST_ACC);
        end
        push2(16'h1111, 1'b0);
        tests++;
        if (st2 !== ST_WR || lif2.addr !== 16'hFFFF || lif2.instr !== 16'h1111) begin
            fails++; $display("FAIL wrap_w0 got %b %h %h want %b FFFF 1111", st2, lif2.addr, lif2.instr, ST_WR);
        end
        lif2.in_valid = 1'b1; lif2.in_data = 16'h2222;
        tick();
        tests++;
        if (st2 !== ST_ERR) begin fails++; $display("FAIL wrap_err got %b want %b", st2, ST_ERR); end
        tick();
        tests++;
        if (st2 !== ST_ERR) begin fails++; $display("FAIL wrap_sticky got %b want %b", st2, ST_ERR); end
        lif2.in_valid = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tests++;
        if (st2 !== ST_ACC) begin fails++; $display("FAIL wrap_clear got %b want %b", st2, ST_ACC); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_cksum();
        pulse_start();
        push(16'h0001, 1'b0);
        tick();
        push(16'h0002, 1'b1);
        tick();
        tests++;
        if (st !== 5'b01100) begin fails++; $display("FAIL ck_phase got %b want 01100", st); end
        push(16'h0003, 1'b0);
        tick();
        tick();
        tests++;
        if (st !== ST_RUN) begin fails++; $display("FAIL ck_good got %b want %b", st, ST_RUN); end
        pulse_start();
        push(16'h0001, 1'b0);
        tick();
        push(16'h0002, 1'b1);
        tick();
        push(16'h0004, 1'b0);
        tests++;
        if (st !== ST_ERR) begin fails++; $display("FAIL ck_bad got %b want %b", st, ST_ERR); end
    endtask
`endif

    initial begin
        tests = 0; fails = 0;
        start = 1'b0; start2 = 1'b0;
        lif.in_valid  = 1'b0; lif.in_data  = '0; lif.in_last  = 1'b0;
        lif2.in_valid = 1'b0; lif2.in_data = '0; lif2.in_last = 1'b0;
        test_reset();
        test_load();
        test_reload();
        test_stall();
        test_reset_mid_load();
        test_start_ignored();
        test_wrap();
`ifdef LOADER_CHECKSUM_EN
        test_cksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/risc16_prog_loader.md
RISC16_PROG_LOADER -- requirements
Module: risc16_prog_loader

Interface
REQ-001 Parameter WORD_LENGTH, default 16: width of the instruction word and the address bus.
REQ-002 Parameter BASE_ADDR, default 16'h0000: address of the first programmed word.
REQ-003 Parameter RST_CYCLES, default 2: number of clock cycles that sys_rst stays high after programming ends.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: single-cycle pulse that begins a load session.
REQ-007 Port in_valid, input, 1: a word is present on in_data.
REQ-008 Port in_data, input, WORD_LENGTH: program word.
REQ-009 Port in_last, input, 1: marks the final program word; qualified by in_valid.
REQ-010 Port in_ready, output, 1: loader accepts a word this cycle.
REQ-011 Port pen, output, 1: program-enable to the RiSC16 system.
REQ-012 Port addr, output, WORD_LENGTH: instruction-memory write address.
REQ-013 Port instr, output, WORD_LENGTH: instruction-memory write data.
REQ-014 Port sys_rst, output, 1: active-high reset to the RiSC16 system.
REQ-015 Port done, output, 1: high while the system is running a loaded program.
REQ-016 Port err, output, 1: sticky load error; cleared only by start or rst.

Function
REQ-017 The loader SHALL implement the states IDLE, ACCEPT, WRITE, FLUSH, RUN and ERROR, with all outputs registered.
REQ-018 IDLE: sys_rst=1, pen=0, in_ready=0; start moves to ACCEPT and sets addr=BASE_ADDR, count=0, err=0.
REQ-019 ACCEPT: sys_rst=1, pen=1, in_ready=1; on in_valid&in_ready, latch instr=in_data and move to WRITE.
REQ-020 WRITE (exactly one cycle): pen=1, in_ready=0, addr and instr held stable so the system samples them on this edge.
REQ-021 On leaving WRITE, the loader SHALL go to FLUSH if the latched word had in_last=1; otherwise it SHALL increment addr by 1 and return to ACCEPT. Throughput is one word per 2 cycles.
REQ-022 FLUSH: pen=0, sys_rst=1 for exactly RST_CYCLES cycles, then go to RUN.
REQ-023 RUN: sys_rst=0, pen=0, done=1; start returns to ACCEPT with sys_rst=1 in the next cycle (reprogramming).
REQ-024 Address wrap: accepting a non-last word at addr=all-ones SHALL move to ERROR instead of wrapping.
REQ-025 ERROR: err=1, sys_rst=1, pen=0, in_ready=0, done=0; only start or rst leaves this state.
REQ-026 Priority: start SHALL be ignored in ACCEPT, WRITE and FLUSH; the in_valid/in_last inputs SHALL be ignored outside ACCEPT.
REQ-027 in_ready SHALL be registered and SHALL depend only on state, never combinationally on in_valid.

Reset
REQ-028 While rst=0, the loader SHALL enter IDLE asynchronously with sys_rst=1, pen=0, in_ready=0, addr=BASE_ADDR, instr=0, done=0, err=0, and clear the checksum and counters.
REQ-029 Reset asserted mid-load SHALL abandon the session; no further pen pulse may follow until a new start.

Configuration
REQ-030 With LOADER_CHECKSUM_EN defined, the loader SHALL keep a WORD_LENGTH-bit modular sum of the written words; after the in_last word it SHALL accept one extra word in ACCEPT without writing it (pen=0 in that cycle); a match goes to FLUSH and a mismatch goes to ERROR.
REQ-031 Without LOADER_CHECKSUM_EN, the in_last word SHALL go directly to FLUSH and no checksum logic SHALL be synthesized.

Structure
REQ-032 A shared package SHALL hold the state encoding constants and the default RST_CYCLES value.
REQ-033 A single sub-module, risc16_loader_cksum (accumulator plus compare), SHALL be instantiated only under LOADER_CHECKSUM_EN.

Verification
REQ-034 Start, then words 6A00, 6D00 and 0903 (last) -> pen writes at addr 0000, 0001 and 0002 with matching instr, then sys_rst high for 2 cycles, then sys_rst=0 and done=1.
REQ-035 in_valid held low for 5 cycles in ACCEPT -> in_ready stays 1, no write occurs, and addr is unchanged.
REQ-036 BASE_ADDR=FFFF and two words sent -> first word is written at FFFF, then err=1, sys_rst stays 1, done=0.
REQ-037 rst pulled low during the second WRITE -> outputs return to reset values immediately, and no pen activity occurs until the next start.
REQ-038 start in RUN -> sys_rst=1 next cycle, then a reload of 1 word (in_last=1) at BASE_ADDR completes and done=1 again.
REQ-039 With LOADER_CHECKSUM_EN, words 0001 and 0002 (last) followed by checksum 0003 -> RUN; followed by checksum 0004 instead -> ERROR with err=1.
